// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared CPU memory-system constants.
//   - memory command encodings (MNONE/MREAD/MWRITE, 2'b11 behaves as MNONE)
//   - arbiter FSM state encodings (2-bit)
//   - default addresses of the memory-mapped LED register and switch port
//   - requester identifier type used for ownership and round-robin history
package mem_arbiter_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles every signal around the memory arbiter.
//   Requester ports A and B : req, cmd, addr, wdata in; ack, rdata out.
//   RAM side                : ram_addr, ram_we, ram_din out; ram_dout in.
//   I/O                     : sw_in in; led_out out.
//   Status                  : busy, state_dbg (FSM state for checkers).
//
// Handshake: a requester raises req with cmd/addr/wdata stable and keeps
// them stable until it observes ack (a single-cycle pulse). On the clock
// edge where ack is seen it must drop req or present a new request; a req
// still high in IDLE is taken as a new transaction. rdata is meaningful only
// while ack is high and is 0 otherwise.
interface mem_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic          req_a;
  logic [1:0]    cmd_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          ack_a;
  logic [DW-1:0] rdata_a;

  logic          req_b;
  logic [1:0]    cmd_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          ack_b;
  logic [DW-1:0] rdata_b;

  logic [AW-2:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [7:0]    sw_in;
  logic [7:0]    led_out;
  logic          busy;
  logic [1:0]    state_dbg;

  modport slave (
    input  req_a, cmd_a, addr_a, wdata_a,
    input  req_b, cmd_b, addr_b, wdata_b,
    input  ram_dout, sw_in,
    output ack_a, rdata_a, ack_b, rdata_b,
    output ram_addr, ram_we, ram_din,
    output led_out, busy, state_dbg
  );

  modport master (
    output req_a, cmd_a, addr_a, wdata_a,
    output req_b, cmd_b, addr_b, wdata_b,
    output ram_dout, sw_in,
    input  ack_a, rdata_a, ack_b, rdata_b,
    input  ram_addr, ram_we, ram_din,
    input  led_out, busy, state_dbg
  );
endinterface

// File: rtl/mem_addr_decode.sv
// mem_addr_decode: combinational address/command decoder.
//   addr   : requester address (AW bits), upper bit selects the I/O page
//   cmd    : memory command
//   is_ram : address lies in the RAM page (addr[AW-1]=0)
//   is_led : address is the LED register
//   is_sw  : address is the switch port
//   ram_wr : command writes RAM
//   led_wr : command writes the LED register
// Writes to the switch port or any other I/O-page address decode to no
// write strobe at all, so they are silently dropped.
module mem_addr_decode
  import mem_arbiter_pkg::*;
#(
  parameter int            AW       = 9,
  parameter logic [AW-1:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [AW-1:0] SW_ADDR  = SW_ADDR_DEF
) (
  input  logic [AW-1:0] addr,
  input  logic [1:0]    cmd,
  output logic          is_ram,
  output logic          is_led,
  output logic          is_sw,
  output logic          ram_wr,
  output logic          led_wr
);

  logic is_write;

  always_comb begin
    is_write = (cmd == MWRITE);
    is_ram   = ~addr[AW-1];
    is_led   = (addr == LED_ADDR);
    is_sw    = (addr == SW_ADDR);
    ram_wr   = is_write & is_ram;
    led_wr   = is_write & is_led;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM plus the LED/switch I/O between
// two requesters (A = CPU, B = debug/loader) with round-robin arbitration.
// Each transaction takes three cycles: IDLE (arbitrate) -> ACCESS (drive
// RAM) -> RESP (ack + read data) -> IDLE.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_arbiter_if slave view (requesters, RAM, I/O, status)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int            AW       = 9,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [AW-1:0] SW_ADDR  = SW_ADDR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  mem_arbiter_if.slave    bus
);

  logic [1:0]    state;
  port_e         owner;
  port_e         last_grant;
  logic [7:0]    led_q;

  // Live view of the owning port; requesters hold their inputs stable
  // until ack, so nothing is latched here.
  logic [1:0]    o_cmd;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata;

  logic          is_ram;
  logic          is_led;
  logic          is_sw;
  logic          ram_wr;
  logic          led_wr;
  logic          is_read;
  logic          in_access;
  logic          in_resp;
  logic [DW-1:0] rd_mux;

  always_comb begin
    if (owner == PORT_B) begin
      o_cmd   = bus.cmd_b;
      o_addr  = bus.addr_b;
      o_wdata = bus.wdata_b;
    end else begin
      o_cmd   = bus.cmd_a;
      o_addr  = bus.addr_a;
      o_wdata = bus.wdata_a;
    end
  end

  mem_addr_decode #(
    .AW       (AW),
    .LED_ADDR (LED_ADDR),
    .SW_ADDR  (SW_ADDR)
  ) u_decode (
    .addr   (o_addr),
    .cmd    (o_cmd),
    .is_ram (is_ram),
    .is_led (is_led),
    .is_sw  (is_sw),
    .ram_wr (ram_wr),
    .led_wr (led_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= PORT_A;
      last_grant <= PORT_B;
      led_q      <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_a && bus.req_b) begin
            // Tie: the port that did not win last time goes first.
            owner <= (last_grant == PORT_B) ? PORT_A : PORT_B;
            state <= ST_ACCESS;
          end else if (bus.req_a) begin
            owner <= PORT_A;
            state <= ST_ACCESS;
          end else if (bus.req_b) begin
            owner <= PORT_B;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (led_wr) begin
            led_q <= o_wdata[7:0];
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          last_grant <= owner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_access = (state == ST_ACCESS);
    in_resp   = (state == ST_RESP);
    is_read   = (o_cmd == MREAD);

    // ram_dout is registered in the RAM, so the address must stay on the
    // bus through RESP for the read data to line up with ack.
    bus.ram_addr = (in_access || in_resp) ? o_addr[AW-2:0] : '0;
    bus.ram_we   = in_access & ram_wr;
    bus.ram_din  = in_access ? o_wdata : '0;

    rd_mux = '0;
    if (is_read) begin
      if (is_ram) begin
        rd_mux = bus.ram_dout;
      end else if (is_sw) begin
        rd_mux = {{(DW-8){1'b0}}, bus.sw_in};
      end else if (is_led) begin
        rd_mux = {{(DW-8){1'b0}}, led_q};
      end
    end

    bus.ack_a     = in_resp && (owner == PORT_A);
    bus.ack_b     = in_resp && (owner == PORT_B);
    bus.rdata_a   = bus.ack_a ? rd_mux : '0;
    bus.rdata_b   = bus.ack_b ? rd_mux : '0;
    bus.led_out   = led_q;
    bus.busy      = (state != ST_IDLE);
    bus.state_dbg = state;
  end

endmodule
